// File: rtl/ir_nec_receiver.sv
// NEC infrared frame decoder: synchronizes the demodulator pin and times marks/spaces in 10 us ticks.
// Define IR_NEC_INVERSE_CHECK_EN to reject data frames whose top byte is not the inverse of the next byte.
`timescale 1ns/1ps
module ir_nec_receiver #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_rx,
    output logic [31:0] ir_command,
    output logic        ir_data_ready,
    output logic        ir_repeat,
    output logic        ir_error
);
    localparam int TICK_DIV = (CLK_FREQ_HZ / 100_000 > 1) ? CLK_FREQ_HZ / 100_000 : 1;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    localparam logic [9:0] WIDTH_MAX  = 10'd1023;
    localparam logic [9:0] LEAD_MIN   = 10'd800;
    localparam logic [9:0] LEAD_MAX   = 10'd1000;
    localparam logic [9:0] SPACE_MIN  = 10'd400;
    localparam logic [9:0] SPACE_MAX  = 10'd500;
    localparam logic [9:0] RPT_MIN    = 10'd200;
    localparam logic [9:0] RPT_MAX    = 10'd250;
    localparam logic [9:0] SHORT_MIN  = 10'd40;
    localparam logic [9:0] SHORT_MAX  = 10'd70;
    localparam logic [9:0] ONE_MIN    = 10'd140;
    localparam logic [9:0] ONE_MAX    = 10'd190;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    logic [1:0]       sync_q, sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic             fall_q, fall_d;
    logic             rise_q, rise_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [9:0]       width_q, width_d;
    state_t           state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      shift_q, shift_d;
    logic [31:0]      cmd_q, cmd_d;
    logic             repeat_q, repeat_d;
    logic             wait_rise_q, wait_rise_d;
    logic             ready_q, ready_d;
    logic             rpt_pulse_q, rpt_pulse_d;
    logic             err_q, err_d;
    logic             tick;
    logic             strobe;
    logic             go_err;

    function automatic logic in_range(input logic [9:0] w, input logic [9:0] lo, input logic [9:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Pin synchronizer, edge strobes, tick prescaler and saturating width counter.
    always_comb begin
        sync_d    = {sync_q[0], ir_rx};
        rx_prev_d = sync_q[1];
        fall_d    = rx_prev_q & ~sync_q[1];
        rise_d    = ~rx_prev_q & sync_q[1];
        tick      = (pre_q == PRE_MAX);
        pre_d     = tick ? '0 : pre_q + 1'b1;
        strobe    = fall_q | rise_q;
        if (strobe)
            width_d = '0;
        else if (tick && (width_q != WIDTH_MAX))
            width_d = width_q + 10'd1;
        else
            width_d = width_q;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cmd_d       = cmd_q;
        repeat_d    = repeat_q;
        wait_rise_d = wait_rise_q;
        ready_d     = 1'b0;
        rpt_pulse_d = 1'b0;
        err_d       = 1'b0;
        go_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_q)
                    wait_rise_d = 1'b0;
                if (fall_q && !wait_rise_q) begin
                    state_d   = LEAD_MARK;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    repeat_d  = 1'b0;
                end
            end
            LEAD_MARK: begin
                if (rise_q) begin
                    if (in_range(width_q, LEAD_MIN, LEAD_MAX))
                        state_d = LEAD_SPACE;
                    else
                        go_err = 1'b1;
                end
            end
            LEAD_SPACE: begin
                if (fall_q) begin
                    if (in_range(width_q, SPACE_MIN, SPACE_MAX)) begin
                        state_d = BIT_MARK;
                    end else if (in_range(width_q, RPT_MIN, RPT_MAX)) begin
                        state_d  = STOP_MARK;
                        repeat_d = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            BIT_MARK: begin
                if (rise_q) begin
                    if (in_range(width_q, SHORT_MIN, SHORT_MAX))
                        state_d = BIT_SPACE;
                    else
                        go_err = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (fall_q) begin
                    if (in_range(width_q, SHORT_MIN, SHORT_MAX) || in_range(width_q, ONE_MIN, ONE_MAX)) begin
                        shift_d   = {in_range(width_q, ONE_MIN, ONE_MAX), shift_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            STOP_MARK: begin
                if (rise_q) begin
                    if (!in_range(width_q, SHORT_MIN, SHORT_MAX)) begin
                        go_err = 1'b1;
                    end else if (repeat_q) begin
                        state_d     = IDLE;
                        rpt_pulse_d = 1'b1;
                    end else begin
`ifdef IR_NEC_INVERSE_CHECK_EN
                        if (shift_q[31:24] != ~shift_q[23:16]) begin
                            go_err = 1'b1;
                        end else begin
                            state_d = IDLE;
                            cmd_d   = shift_q;
                            ready_d = 1'b1;
                        end
`else
                        state_d = IDLE;
                        cmd_d   = shift_q;
                        ready_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && !strobe && (width_q == WIDTH_MAX))
            go_err = 1'b1;

        // An abort mid-mark must not let the trailing rise be mistaken for a new leader.
        if (go_err) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            shift_d     = '0;
            repeat_d    = 1'b0;
            err_d       = 1'b1;
            wait_rise_d = ~rx_prev_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            fall_q      <= 1'b0;
            rise_q      <= 1'b0;
            pre_q       <= '0;
            width_q     <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cmd_q       <= '0;
            repeat_q    <= 1'b0;
            wait_rise_q <= 1'b0;
            ready_q     <= 1'b0;
            rpt_pulse_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rx_prev_q   <= rx_prev_d;
            fall_q      <= fall_d;
            rise_q      <= rise_d;
            pre_q       <= pre_d;
            width_q     <= width_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cmd_q       <= cmd_d;
            repeat_q    <= repeat_d;
            wait_rise_q <= wait_rise_d;
            ready_q     <= ready_d;
            rpt_pulse_q <= rpt_pulse_d;
            err_q       <= err_d;
        end
    end

    assign ir_command    = cmd_q;
    assign ir_data_ready = ready_q;
    assign ir_repeat     = rpt_pulse_q;
    assign ir_error      = err_q;
endmodule

// File: tb/tb_ir_nec_receiver.sv
// Randomized bench for ir_nec_receiver: frames are built as mark/space duration lists and
// judged by a duration-rule model; the clock is set so one 10 us tick equals one cycle.
`timescale 1ns/1ps
module tb_ir_nec_receiver;
    localparam int CLK_HZ = 100_000;
    localparam int K_NONE = 0;
    localparam int K_DATA = 1;
    localparam int K_REP  = 2;
    localparam int K_ERR  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_rx;
    logic [31:0] ir_command;
    logic        ir_data_ready;
    logic        ir_repeat;
    logic        ir_error;

    int          segQ[$];
    int          numChecks = 0;
    int          numErrors = 0;
    int          readyCnt = 0;
    int          repeatCnt = 0;
    int          errorCnt = 0;
    int          cycleCount = 0;
    int          readyCycle = 0;
    int          lastRiseCycle = 0;
    logic        prevPulse = 1'b0;
    logic        anyPulse;
    logic [31:0] expCmd = 32'h0;

    ir_nec_receiver #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk          (clk),
        .reset        (reset),
        .ir_rx        (ir_rx),
        .ir_command   (ir_command),
        .ir_data_ready(ir_data_ready),
        .ir_repeat    (ir_repeat),
        .ir_error     (ir_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    always @(posedge clk) cycleCount++;

    // Pulse monitor: counts each output pulse and checks exclusivity and spacing.
    always @(negedge clk) begin
        anyPulse = ir_data_ready | ir_repeat | ir_error;
        if (anyPulse) begin
            checkOutput("exclusive", 32'(ir_data_ready) + 32'(ir_repeat) + 32'(ir_error), 32'd1);
            checkOutput("backToBack", {31'b0, prevPulse}, 32'd0);
        end
        if (ir_data_ready) begin
            readyCnt++;
            readyCycle = cycleCount;
        end
        if (ir_repeat) repeatCnt++;
        if (ir_error)  errorCnt++;
        prevPulse = anyPulse;
    end

    function automatic int jit(input int nominal);
        return nominal + int'($urandom_range(8)) - 4;
    endfunction

    function automatic bit inR(input int w, input int lo, input int hi);
        return (w >= lo) && (w <= hi);
    endfunction

    task automatic buildData(input logic [31:0] val);
        segQ.delete();
        segQ.push_back(jit(900));
        segQ.push_back(jit(450));
        for (int k = 0; k < 32; k++) begin
            segQ.push_back(jit(56));
            segQ.push_back(val[k] ? jit(169) : jit(56));
        end
        segQ.push_back(jit(56));
    endtask

    task automatic buildRepeat();
        segQ.delete();
        segQ.push_back(jit(900));
        segQ.push_back(jit(225));
        segQ.push_back(jit(56));
    endtask

    // Reference: walk the durations through the NEC timing rules.
    task automatic predict(output int kind, output logic [31:0] val);
        int n;
        n    = segQ.size();
        kind = K_NONE;
        val  = 32'h0;
        if (n < 1) return;
        if (!inR(segQ[0], 800, 1000)) begin kind = K_ERR; return; end
        if (n < 2) return;
        if (inR(segQ[1], 200, 250)) begin
            if (n < 3) return;
            kind = inR(segQ[2], 40, 70) ? K_REP : K_ERR;
            return;
        end
        if (!inR(segQ[1], 400, 500)) begin kind = K_ERR; return; end
        for (int k = 0; k < 32; k++) begin
            if (n <= 2 + 2 * k) return;
            if (!inR(segQ[2 + 2 * k], 40, 70)) begin kind = K_ERR; return; end
            if (n <= 3 + 2 * k) return;
            if (inR(segQ[3 + 2 * k], 40, 70))        val[k] = 1'b0;
            else if (inR(segQ[3 + 2 * k], 140, 190)) val[k] = 1'b1;
            else begin kind = K_ERR; return; end
        end
        if (n <= 66) return;
        if (!inR(segQ[66], 40, 70)) begin kind = K_ERR; return; end
`ifdef IR_NEC_INVERSE_CHECK_EN
        if (val[31:24] != ~val[23:16]) begin kind = K_ERR; return; end
`endif
        kind = K_DATA;
    endtask

    task automatic applyStimulus(input int abortIdx);
        for (int i = 0; i < segQ.size(); i++) begin
            ir_rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            if (i == abortIdx) begin
                repeat (segQ[i] / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                checkOutput("rstCmd", ir_command, 32'h0);
                checkOutput("rstPulses", {29'b0, ir_data_ready, ir_repeat, ir_error}, 32'h0);
                ir_rx = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                break;
            end
            repeat (segQ[i]) @(negedge clk);
        end
        ir_rx = 1'b1;
        lastRiseCycle = cycleCount;
        repeat (300) @(negedge clk);
    endtask

    task automatic runFrame(input string name, input int abortIdx);
        int kind;
        int r0, p0, e0;
        logic [31:0] val;
        r0 = readyCnt;
        p0 = repeatCnt;
        e0 = errorCnt;
        predict(kind, val);
        applyStimulus(abortIdx);
        if (abortIdx >= 0) begin
            kind   = K_NONE;
            expCmd = 32'h0;
        end
        if (kind == K_DATA) expCmd = val;
        checkOutput({name, ":ready"},  32'(readyCnt - r0),  (kind == K_DATA) ? 32'd1 : 32'd0);
        checkOutput({name, ":repeat"}, 32'(repeatCnt - p0), (kind == K_REP)  ? 32'd1 : 32'd0);
        checkOutput({name, ":error"},  32'(errorCnt - e0),  (kind == K_ERR)  ? 32'd1 : 32'd0);
        checkOutput({name, ":cmd"},    ir_command, expCmd);
        if (kind == K_DATA)
            checkOutput({name, ":latency"},
                        32'((readyCycle - lastRiseCycle >= 1) && (readyCycle - lastRiseCycle <= 8)), 32'd1);
    endtask

    initial begin
        logic [31:0] val;
        reset = 1'b1;
        ir_rx = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("resetCmd", ir_command, 32'h0);
        checkOutput("resetPulses", {29'b0, ir_data_ready, ir_repeat, ir_error}, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] valid data frame");
        buildData(32'hE9166B86);
        runFrame("frameE916", -1);

        $display("[TB] repeat frame");
        buildRepeat();
        runFrame("repeat", -1);

        $display("[TB] short leader then recovery");
        segQ.delete();
        segQ.push_back(700);
        runFrame("shortLead", -1);
        buildData(32'hED126B86);
        runFrame("frameED12", -1);

        $display("[TB] timeout after bit 10");
        buildData($urandom);
        segQ = segQ[0:22];
        segQ.push_back(1200);
        runFrame("timeout", -1);

        $display("[TB] inverse byte mismatch frame");
        buildData(32'hED136B86);
        runFrame("frameED13", -1);

        $display("[TB] reset during bit 20");
        buildData($urandom);
        runFrame("midReset", 42);
        buildData(32'hE9166B86);
        runFrame("afterReset", -1);

        $display("[TB] random frames");
        for (int r = 0; r < 3; r++) begin
            val = $urandom;
            if (r == 0) val[31:24] = ~val[23:16];
            buildData(val);
            runFrame("random", -1);
        end
        buildRepeat();
        runFrame("randRepeat", -1);

        $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
        $finish;
    end
endmodule
